exposure_sequencer: RTL and testbench



---
 rtl/exposure_sequencer_if.sv | 27 ++
 rtl/exposure_sequencer.sv | 143 ++++++++++++++
 tb/tb_exposure_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/exposure_sequencer_if.sv
// Parameter/control bundle between the UV controller and the exposure sequencer.
// The master drives timing parameters and requests; the slave reports relay state and progress.
interface exposure_sequencer_if;
  logic [13:0] on_time_ms;
  logic [13:0] off_time_ms;
  logic [13:0] repetitions;
  logic        start;
  logic        abort;
  logic        relay;
  logic        busy;
  logic [1:0]  phase;
  logic [13:0] elapsed_ms;
  logic [13:0] rep_count;
  logic        done;
  logic        aborted;
  logic        param_err;

  modport master (
    output on_time_ms, off_time_ms, repetitions, start, abort,
    input  relay, busy, phase, elapsed_ms, rep_count, done, aborted, param_err
  );

  modport slave (
    input  on_time_ms, off_time_ms, repetitions, start, abort,
    output relay, busy, phase, elapsed_ms, rep_count, done, aborted, param_err
  );
endinterface

// File: rtl/exposure_sequencer.sv
// Relay timing engine: latches on/off/repetition settings at start and runs ON/OFF cycles
// with millisecond resolution, reporting phase and progress for the display.
//   state | meaning
//   IDLE  | relay off, counters hold last values for display
//   ON    | relay on, counting on_time ms
//   OFF   | relay off, counting off_time ms between repetitions
module exposure_sequencer #(
  parameter int TICKS_PER_MS = 16000,
  parameter int MAX_VAL      = 9999
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  exposure_sequencer_if.slave  bus
);

  localparam int PW = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0] on_q, on_d;
  logic [13:0] off_q, off_d;
  logic [13:0] reps_q, reps_d;
  logic [13:0] elapsed_q, elapsed_d;
  logic [13:0] rep_q, rep_d;
  logic        relay_q, relay_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        param_err_q, param_err_d;

  logic [13:0] on_c, off_c, reps_c;
  logic [13:0] elapsed_inc, rep_inc;
  logic        tick;

  function automatic logic [13:0] clamp(input logic [13:0] v);
    return (v > 14'(MAX_VAL)) ? 14'(MAX_VAL) : v;
  endfunction

  assign on_c        = clamp(bus.on_time_ms);
  assign off_c       = clamp(bus.off_time_ms);
  assign reps_c      = clamp(bus.repetitions);
  assign tick        = (presc_q == PW'(TICKS_PER_MS - 1));
  assign elapsed_inc = elapsed_q + 14'd1;
  assign rep_inc     = rep_q + 14'd1;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      on_q        <= '0;
      off_q       <= '0;
      reps_q      <= '0;
      elapsed_q   <= '0;
      rep_q       <= '0;
      relay_q     <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      param_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      on_q        <= on_d;
      off_q       <= off_d;
      reps_q      <= reps_d;
      elapsed_q   <= elapsed_d;
      rep_q       <= rep_d;
      relay_q     <= relay_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      param_err_q <= param_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    on_d      = on_q;
    off_d     = off_q;
    reps_d    = reps_q;
    elapsed_d = elapsed_q;
    rep_d     = rep_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort && on_c != 14'd0 && reps_c != 14'd0) begin
          state_d   = S_ON;
          on_d      = on_c;
          off_d     = off_c;
          reps_d    = reps_c;
          elapsed_d = '0;
          rep_d     = '0;
          presc_d   = '0;
        end
      end
      S_ON, S_OFF: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          // The tick wraps the prescaler to zero, which also serves as the phase-entry clear.
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            elapsed_d = elapsed_inc;
            if (state_q == S_ON && elapsed_inc == on_q) begin
              rep_d = rep_inc;
              if (rep_inc == reps_q) begin
                state_d = S_IDLE;
              end else begin
                state_d   = (off_q == 14'd0) ? S_ON : S_OFF;
                elapsed_d = '0;
              end
            end else if (state_q == S_OFF && elapsed_inc == off_q) begin
              state_d   = S_ON;
              elapsed_d = '0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status pulses are mutually exclusive: each keys off a distinct state/abort combination.
  always_comb begin
    relay_d     = (state_d == S_ON);
    done_d      = (state_q != S_IDLE) && !bus.abort && (state_d == S_IDLE);
    aborted_d   = (state_q != S_IDLE) && bus.abort;
    param_err_d = (state_q == S_IDLE) && bus.start && !bus.abort && (state_d == S_IDLE);
  end

  assign bus.relay      = relay_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.phase      = state_q;
  assign bus.elapsed_ms = elapsed_q;
  assign bus.rep_count  = rep_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
  assign bus.param_err  = param_err_q;

endmodule

// File: tb/tb_exposure_sequencer.sv
// Directed bench for exposure_sequencer: a vector table of full sequences plus
// hand-written abort, busy-start, reset and saturation scenarios.
module tb_exposure_sequencer;

  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  exposure_sequencer_if ifc4();
  exposure_sequencer_if ifc2();

  exposure_sequencer #(.TICKS_PER_MS(4), .MAX_VAL(9999)) dut4 (
    .CLK(CLK), .reset_n(reset_n), .bus(ifc4)
  );
  exposure_sequencer #(.TICKS_PER_MS(2), .MAX_VAL(9999)) dut2 (
    .CLK(CLK), .reset_n(reset_n), .bus(ifc2)
  );

  typedef struct {
    int on;
    int off;
    int reps;
    int exp_perr;
    int exp_busy;
    int exp_high;
    int exp_rises;
    int exp_rep;
    int exp_el;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int busy_n = 0, high_n = 0, rises = 0, dn = 0, pe = 0, done_bad = 0;
    logic prev = 1'b0;
    ifc4.on_time_ms  = 14'(v.on);
    ifc4.off_time_ms = 14'(v.off);
    ifc4.repetitions = 14'(v.reps);
    ifc4.start = 1'b1;
    @(negedge CLK);
    ifc4.start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (ifc4.busy) busy_n++;
      if (ifc4.relay) high_n++;
      if (ifc4.relay && !prev) rises++;
      if (ifc4.param_err) pe++;
      if (ifc4.done) begin
        dn++;
        if (!(prev && !ifc4.relay)) done_bad++;
      end
      prev = ifc4.relay;
      @(negedge CLK);
    end
    check($sformatf("vec%0d param_err", idx), pe, v.exp_perr);
    check($sformatf("vec%0d done", idx), dn, 1 - v.exp_perr);
    check($sformatf("vec%0d busy_cycles", idx), busy_n, v.exp_busy);
    check($sformatf("vec%0d relay_high", idx), high_n, v.exp_high);
    check($sformatf("vec%0d relay_rises", idx), rises, v.exp_rises);
    check($sformatf("vec%0d done_at_fall", idx), done_bad, 0);
    if (v.exp_perr == 0) begin
      check($sformatf("vec%0d rep_count", idx), int'(ifc4.rep_count), v.exp_rep);
      check($sformatf("vec%0d elapsed", idx), int'(ifc4.elapsed_ms), v.exp_el);
    end
  endtask

  initial begin
    int dn, bad, pe, busy_n, high_n;
    ifc4.on_time_ms = '0; ifc4.off_time_ms = '0; ifc4.repetitions = '0;
    ifc4.start = 1'b0; ifc4.abort = 1'b0;
    ifc2.on_time_ms = '0; ifc2.off_time_ms = '0; ifc2.repetitions = '0;
    ifc2.start = 1'b0; ifc2.abort = 1'b0;

    //            on off reps perr busy high rises rep el
    vecs[0] = '{3, 2, 2, 0, 32, 24, 2, 2, 3};
    vecs[1] = '{2, 0, 3, 0, 24, 24, 1, 3, 2};
    vecs[2] = '{0, 5, 2, 1,  0,  0, 0, 0, 0};
    vecs[3] = '{3, 1, 0, 1,  0,  0, 0, 0, 0};
    vecs[4] = '{1, 1, 1, 0,  4,  4, 1, 1, 1};
    vecs[5] = '{1, 3, 2, 0, 20,  8, 2, 2, 1};

    repeat (2) @(negedge CLK);
    check("reset relay", int'(ifc4.relay), 0);
    check("reset busy", int'(ifc4.busy), 0);
    check("reset phase", int'(ifc4.phase), 0);
    check("reset elapsed", int'(ifc4.elapsed_ms), 0);
    check("reset rep_count", int'(ifc4.rep_count), 0);
    check("reset pulses", int'({ifc4.done, ifc4.aborted, ifc4.param_err}), 0);
    reset_n = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // off=0: elapsed restarts 0,1 each repetition while relay stays high
    ifc4.on_time_ms = 14'd2; ifc4.off_time_ms = 14'd0; ifc4.repetitions = 14'd3;
    ifc4.start = 1'b1;
    @(negedge CLK);
    ifc4.start = 1'b0;
    dn = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k > 1 && k <= 21 && (k % 4) == 1)
        check($sformatf("restart elapsed k%0d", k), int'(ifc4.elapsed_ms), ((k - 1) / 4) % 2);
      if (ifc4.done) dn++;
      @(negedge CLK);
    end
    check("restart done", dn, 1);

    // abort in the 5th cycle of OFF, then immediate restart
    ifc4.on_time_ms = 14'd3; ifc4.off_time_ms = 14'd5; ifc4.repetitions = 14'd4;
    ifc4.start = 1'b1;
    @(negedge CLK);
    ifc4.start = 1'b0;
    dn = 0;
    for (int k = 1; k < 17; k++) begin
      if (ifc4.done) dn++;
      @(negedge CLK);
    end
    check("abort pre phase", int'(ifc4.phase), 2);
    ifc4.abort = 1'b1;
    @(negedge CLK);
    if (ifc4.done) dn++;
    check("abort relay", int'(ifc4.relay), 0);
    check("abort pulse", int'(ifc4.aborted), 1);
    check("abort phase", int'(ifc4.phase), 0);
    check("abort rep_count", int'(ifc4.rep_count), 1);
    check("abort elapsed", int'(ifc4.elapsed_ms), 1);
    ifc4.abort = 1'b0;
    ifc4.on_time_ms = 14'd1; ifc4.off_time_ms = 14'd0; ifc4.repetitions = 14'd1;
    ifc4.start = 1'b1;
    @(negedge CLK);
    ifc4.start = 1'b0;
    check("abort no done", dn, 0);
    check("restart busy", int'(ifc4.busy), 1);
    check("restart relay", int'(ifc4.relay), 1);
    check("restart aborted low", int'(ifc4.aborted), 0);
    check("restart rep_count", int'(ifc4.rep_count), 0);
    repeat (8) @(negedge CLK);
    check("restart finished", int'(ifc4.rep_count), 1);

    // start together with abort in IDLE must not start
    ifc4.on_time_ms = 14'd2; ifc4.repetitions = 14'd1;
    ifc4.start = 1'b1; ifc4.abort = 1'b1;
    @(negedge CLK);
    ifc4.start = 1'b0; ifc4.abort = 1'b0;
    check("start+abort busy", int'(ifc4.busy), 0);
    check("start+abort pulses", int'({ifc4.done, ifc4.aborted, ifc4.param_err}), 0);
    @(negedge CLK);

    // start while busy is ignored (including invalid parameters)
    ifc4.on_time_ms = 14'd1; ifc4.off_time_ms = 14'd1; ifc4.repetitions = 14'd2;
    ifc4.start = 1'b1;
    @(negedge CLK);
    ifc4.start = 1'b0;
    pe = 0; busy_n = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 2 || k == 6) begin
        ifc4.on_time_ms = (k == 2) ? 14'd5 : 14'd0;
        ifc4.repetitions = 14'd5;
        ifc4.start = 1'b1;
      end else begin
        ifc4.start = 1'b0;
      end
      if (ifc4.busy) busy_n++;
      if (ifc4.param_err) pe++;
      @(negedge CLK);
    end
    check("busy start param_err", pe, 0);
    check("busy start duration", busy_n, 12);

    // asynchronous reset mid-ON
    ifc4.on_time_ms = 14'd3; ifc4.off_time_ms = 14'd0; ifc4.repetitions = 14'd1;
    ifc4.start = 1'b1;
    @(negedge CLK);
    ifc4.start = 1'b0;
    repeat (3) @(negedge CLK);
    check("pre-reset relay", int'(ifc4.relay), 1);
    reset_n = 1'b0;
    #1;
    check("async reset relay", int'(ifc4.relay), 0);
    @(negedge CLK);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (ifc4.relay || ifc4.busy || ifc4.phase != 2'd0 || ifc4.elapsed_ms != 14'd0 ||
          ifc4.rep_count != 14'd0 || ifc4.done || ifc4.aborted || ifc4.param_err) bad++;
      @(negedge CLK);
    end
    check("post-reset outputs", bad, 0);

    // clamp to 9999 with TICKS_PER_MS=2: ON lasts 19998 cycles
    ifc2.on_time_ms = 14'd12000; ifc2.off_time_ms = 14'd12000; ifc2.repetitions = 14'd1;
    ifc2.start = 1'b1;
    @(negedge CLK);
    ifc2.start = 1'b0;
    high_n = 0; dn = 0;
    for (int k = 0; k < 25000; k++) begin
      if (ifc2.relay) high_n++;
      if (ifc2.done) dn++;
      if (dn != 0) break;
      @(negedge CLK);
    end
    check("sat relay_high", high_n, 19998);
    check("sat done", dn, 1);
    check("sat elapsed", int'(ifc2.elapsed_ms), 9999);
    check("sat rep_count", int'(ifc2.rep_count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
